// File: rtl/spi_xfer_sequencer_if.sv
// Bundle of requester handshakes and the SPI master register-port signals.
// The sequencer takes the master modport; the requesters and SPI master model sit on slave.
interface spi_xfer_sequencer_if #(
  parameter int NREQ  = 2,
  parameter int LEN_W = 8,
  parameter int SS_W  = 16
);
  // Handshake rule for tx: a byte moves on every clock edge where tx_valid and
  // tx_ready of the same port are both high; rx_valid and done are single-cycle
  // pulses with no back-pressure.
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ*SS_W-1:0]  req_ss;
  logic [NREQ-1:0]       grant;
  logic [NREQ*8-1:0]     tx_data;
  logic [NREQ-1:0]       tx_valid;
  logic [NREQ-1:0]       tx_ready;
  logic [7:0]            rx_data;
  logic [NREQ-1:0]       rx_valid;
  logic [NREQ-1:0]       done;
  logic                  spi_select;
  logic                  spi_read_n;
  logic                  spi_write_n;
  logic [2:0]            spi_mem_addr;
  logic [15:0]           spi_data_from_cpu;
  logic [15:0]           spi_data_to_cpu;
  logic                  spi_readyfordata;
  logic                  spi_dataavailable;

  modport master (
    input  req, req_len, req_ss, tx_data, tx_valid,
           spi_data_to_cpu, spi_readyfordata, spi_dataavailable,
    output grant, tx_ready, rx_data, rx_valid, done,
           spi_select, spi_read_n, spi_write_n, spi_mem_addr, spi_data_from_cpu
  );

  modport slave (
    output req, req_len, req_ss, tx_data, tx_valid,
           spi_data_to_cpu, spi_readyfordata, spi_dataavailable,
    input  grant, tx_ready, rx_data, rx_valid, done,
           spi_select, spi_read_n, spi_write_n, spi_mem_addr, spi_data_from_cpu
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Two-port round-robin arbiter that runs one multi-byte SPI transaction per grant
// by programming the SPI master through its 2-cycle register port.
module spi_xfer_sequencer #(
  parameter int NREQ  = 2,
  parameter int LEN_W = 8,
  parameter int SS_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_xfer_sequencer_if.master bus,
  output logic [3:0]           dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_SEL, S_SSON, S_FETCH,
    S_TXW, S_RXWAIT, S_RXRD, S_SSOFF, S_DONE
  } state_t;

  localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

  state_t          state;
  logic [1:0]      ph;
  logic            owner;
  logic            last;
  logic [LEN_W:0]  rem;
  logic [SS_W-1:0] ss_q;

  logic             pick;
  logic [LEN_W-1:0] pick_len;
  logic [SS_W-1:0]  pick_ss;
  logic [7:0]       own_tx;
  logic [NREQ-1:0]  own_mask;
  logic             unused_hi;

  // last holds the port served most recently; the other port wins ties.
  always_comb begin
    pick     = last ? ~bus.req[0] : bus.req[1];
    pick_len = pick ? bus.req_len[2*LEN_W-1:LEN_W] : bus.req_len[LEN_W-1:0];
    pick_ss  = pick ? bus.req_ss[2*SS_W-1:SS_W]    : bus.req_ss[SS_W-1:0];
    own_tx   = owner ? bus.tx_data[15:8] : bus.tx_data[7:0];
    own_mask = {owner, ~owner};
  end

  assign unused_hi = ^bus.spi_data_to_cpu[15:8];
  assign dbg_state = state;

  // Strobes are launched on the edge that enters an access state; ph then counts
  // the two strobe cycles (0,1) and the trailing idle cycle (2).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= S_IDLE;
      ph                    <= 2'd0;
      owner                 <= 1'b0;
      last                  <= 1'b1;
      rem                   <= '0;
      ss_q                  <= '0;
      bus.grant             <= '0;
      bus.tx_ready          <= '0;
      bus.rx_valid          <= '0;
      bus.done              <= '0;
      bus.rx_data           <= 8'h00;
      bus.spi_select        <= 1'b0;
      bus.spi_read_n        <= 1'b1;
      bus.spi_write_n       <= 1'b1;
      bus.spi_mem_addr      <= 3'd0;
      bus.spi_data_from_cpu <= 16'h0000;
    end else begin
      bus.rx_valid <= '0;
      bus.done     <= '0;
      bus.tx_ready <= '0;
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            owner                 <= pick;
            last                  <= pick;
            bus.grant             <= {pick, ~pick};
            rem                   <= {1'b0, pick_len} + CNT_ONE;
            ss_q                  <= pick_ss;
            bus.spi_select        <= 1'b1;
            bus.spi_write_n       <= 1'b0;
            bus.spi_mem_addr      <= 3'd2;
            bus.spi_data_from_cpu <= 16'h0000;
            ph                    <= 2'd0;
            state                 <= S_CLR;
          end
        end
        S_FETCH: begin
          if (bus.tx_ready[owner] && bus.tx_valid[owner]) begin
            bus.spi_select        <= 1'b1;
            bus.spi_write_n       <= 1'b0;
            bus.spi_mem_addr      <= 3'd1;
            bus.spi_data_from_cpu <= {8'h00, own_tx};
            ph                    <= 2'd0;
            state                 <= S_TXW;
          end else if (bus.spi_readyfordata) begin
            bus.tx_ready <= own_mask;
          end
        end
        S_RXWAIT: begin
          if (bus.spi_dataavailable) begin
            bus.spi_select   <= 1'b1;
            bus.spi_read_n   <= 1'b0;
            bus.spi_mem_addr <= 3'd0;
            ph               <= 2'd0;
            state            <= S_RXRD;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          case (ph)
            2'd0: ph <= 2'd1;
            2'd1: begin
              ph              <= 2'd2;
              bus.spi_select  <= 1'b0;
              bus.spi_read_n  <= 1'b1;
              bus.spi_write_n <= 1'b1;
              if (state == S_RXRD) begin
                bus.rx_data  <= bus.spi_data_to_cpu[7:0];
                bus.rx_valid <= own_mask;
                rem          <= rem - CNT_ONE;
              end
            end
            default: begin
              ph <= 2'd0;
              case (state)
                S_CLR: begin
                  bus.spi_select        <= 1'b1;
                  bus.spi_write_n       <= 1'b0;
                  bus.spi_mem_addr      <= 3'd5;
                  bus.spi_data_from_cpu <= ss_q;
                  state                 <= S_SEL;
                end
                S_SEL: begin
                  // SSO on, every interrupt enable off
                  bus.spi_select        <= 1'b1;
                  bus.spi_write_n       <= 1'b0;
                  bus.spi_mem_addr      <= 3'd3;
                  bus.spi_data_from_cpu <= 16'h0400;
                  state                 <= S_SSON;
                end
                S_SSON: state <= S_FETCH;
                S_TXW:  state <= S_RXWAIT;
                S_RXRD: begin
                  if (rem != '0) begin
                    state <= S_FETCH;
                  end else begin
                    bus.spi_select        <= 1'b1;
                    bus.spi_write_n       <= 1'b0;
                    bus.spi_mem_addr      <= 3'd3;
                    bus.spi_data_from_cpu <= 16'h0000;
                    state                 <= S_SSOFF;
                  end
                end
                default: begin
                  bus.done  <= own_mask;
                  bus.grant <= '0;
                  state     <= S_DONE;
                end
              endcase
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a loopback SPI register model.
module tb_spi_xfer_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] dbg_state;

  spi_xfer_sequencer_if #(.NREQ(2), .LEN_W(8), .SS_W(16)) bus ();

  spi_xfer_sequencer #(.NREQ(2), .LEN_W(8), .SS_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- requester TX drivers ----------------
  logic [7:0]  tx_data0, tx_data1;
  logic        tx_valid0, tx_valid1;
  logic [15:0] txq0[$];
  logic [15:0] txq1[$];
  assign bus.tx_valid = {tx_valid1, tx_valid0};
  assign bus.tx_data  = {tx_data1, tx_data0};

  // Queue entry is {stall cycles before offering, byte}.
  initial begin
    logic [15:0] e;
    tx_valid0 = 1'b0; tx_data0 = 8'h00;
    forever begin
      @(negedge clk);
      if (txq0.size() != 0) begin
        e = txq0.pop_front();
        repeat (int'(e[15:8])) @(negedge clk);
        tx_data0 = e[7:0]; tx_valid0 = 1'b1;
        while (!bus.tx_ready[0]) @(negedge clk);
        @(negedge clk);
        tx_valid0 = 1'b0;
      end
    end
  end

  initial begin
    logic [15:0] e;
    tx_valid1 = 1'b0; tx_data1 = 8'h00;
    forever begin
      @(negedge clk);
      if (txq1.size() != 0) begin
        e = txq1.pop_front();
        repeat (int'(e[15:8])) @(negedge clk);
        tx_data1 = e[7:0]; tx_valid1 = 1'b1;
        while (!bus.tx_ready[1]) @(negedge clk);
        @(negedge clk);
        tx_valid1 = 1'b0;
      end
    end
  end

  // ---------------- SPI master register model (MOSI looped to MISO) ----------------
  initial begin
    int   cd;
    logic m_prev_sel;
    cd = 0; m_prev_sel = 1'b0;
    bus.spi_readyfordata  = 1'b1;
    bus.spi_dataavailable = 1'b0;
    bus.spi_data_to_cpu   = 16'h0000;
    forever begin
      @(negedge clk);
      if (reset) begin
        cd = 0; m_prev_sel = 1'b0; bus.spi_dataavailable = 1'b0;
      end else begin
        if (cd != 0) begin
          cd--;
          if (cd == 0) bus.spi_dataavailable = 1'b1;
        end
        if (bus.spi_select && !bus.spi_write_n && !m_prev_sel) begin
          if (bus.spi_mem_addr == 3'd1) begin
            bus.spi_data_to_cpu = {8'h00, bus.spi_data_from_cpu[7:0]};
            cd = 4;
          end
          if (bus.spi_mem_addr == 3'd2) bus.spi_dataavailable = 1'b0;
        end
        if (bus.spi_select && !bus.spi_read_n && bus.spi_mem_addr == 3'd0)
          bus.spi_dataavailable = 1'b0;
        m_prev_sel = bus.spi_select;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [7:0]  exp_q[$];
  logic [19:0] bus_log[$];
  logic [1:0]  grant_log[$];
  int rx_cnt  = 0;
  int wr1_cnt = 0;

  initial begin
    logic prev_sel, prev_grant_any;
    int   sel_len;
    prev_sel = 1'b0; prev_grant_any = 1'b0; sel_len = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_sel = 1'b0; prev_grant_any = 1'b0; sel_len = 0;
      end else begin
        if (bus.spi_select) begin
          if (!prev_sel) begin
            bus_log.push_back({~bus.spi_read_n, bus.spi_mem_addr,
                               bus.spi_read_n ? bus.spi_data_from_cpu : 16'h0000});
            if (!bus.spi_write_n && bus.spi_mem_addr == 3'd1) wr1_cnt++;
          end
          sel_len++;
        end else if (prev_sel) begin
          check("strobe_len", sel_len, 2);
          sel_len = 0;
        end
        prev_sel = bus.spi_select;
        if (bus.rx_valid != 2'b00) begin
          check("rx_owner", {30'd0, bus.rx_valid}, {30'd0, bus.grant});
          if (exp_q.size() == 0) check("rx_unexpected", exp_q.size(), 1);
          else check("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
          rx_cnt++;
        end
        if (bus.tx_ready != 2'b00)
          check("tx_ready_owner", {30'd0, bus.tx_ready & ~bus.grant}, 0);
        if (bus.done != 2'b00)
          check("done_grant_low", {30'd0, bus.grant}, 0);
        if (bus.grant != 2'b00 && !prev_grant_any) grant_log.push_back(bus.grant);
        prev_grant_any = (bus.grant != 2'b00);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (bus.done == 2'b00 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, bus.done != 2'b00}, 1);
  endtask

  task automatic wait_rx(input string tag, input int target, input int budget);
    int n = 0;
    while (rx_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, rx_cnt >= target}, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before end of test");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [19:0] t1_exp [6];
    int base, w, n, sson_n, ssoff_n;

    reset       = 1'b1;
    bus.req     = 2'b00;
    bus.req_len = '0;
    bus.req_ss  = '0;
    repeat (2) @(negedge clk);
    check("rst_grant",    {30'd0, bus.grant}, 0);
    check("rst_select",   {31'd0, bus.spi_select}, 0);
    check("rst_strobes",  {30'd0, bus.spi_read_n, bus.spi_write_n}, 3);
    check("rst_addr",     {29'd0, bus.spi_mem_addr}, 0);
    check("rst_rx_data",  {24'd0, bus.rx_data}, 0);
    check("rst_state",    {28'd0, dbg_state}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Test 1: port 0, single byte 0xA5, full bus sequence.
    t1_exp[0] = {1'b0, 3'd2, 16'h0000};
    t1_exp[1] = {1'b0, 3'd5, 16'h0001};
    t1_exp[2] = {1'b0, 3'd3, 16'h0400};
    t1_exp[3] = {1'b0, 3'd1, 16'h00A5};
    t1_exp[4] = {1'b1, 3'd0, 16'h0000};
    t1_exp[5] = {1'b0, 3'd3, 16'h0000};
    bus_log.delete();
    exp_q.push_back(8'hA5);
    txq0.push_back({8'd0, 8'hA5});
    bus.req_len[7:0] = 8'd0;
    bus.req_ss[15:0] = 16'h0001;
    bus.req[0] = 1'b1;
    @(negedge clk);
    check("t1_grant_lat", {30'd0, bus.grant}, 1);
    check("t1_clr_strobe", {28'd0, bus.spi_select, bus.spi_write_n, bus.spi_mem_addr[1:0]}, 4'b1010);
    wait_done("t1_done_seen", 300);
    check("t1_done_port", {30'd0, bus.done}, 1);
    bus.req[0] = 1'b0;
    check("t1_rx_cnt", rx_cnt, 1);
    check("t1_bus_len", bus_log.size(), 6);
    if (bus_log.size() == 6)
      for (int i = 0; i < 6; i++) check("t1_bus_seq", {12'd0, bus_log[i]}, {12'd0, t1_exp[i]});
    repeat (3) @(negedge clk);

    // Test 2: port 1, three bytes; len/ss changes after grant must be ignored.
    bus_log.delete();
    base = rx_cnt;
    foreach (t1_exp[i]) ;
    txq1.push_back({8'd0, 8'h11}); txq1.push_back({8'd0, 8'h22}); txq1.push_back({8'd0, 8'h33});
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    bus.req_len[15:8] = 8'd2;
    bus.req_ss[31:16] = 16'h0003;
    bus.req[1] = 1'b1;
    @(negedge clk);
    check("t2_grant", {30'd0, bus.grant}, 2);
    bus.req_len[15:8] = 8'd5;
    bus.req_ss[31:16] = 16'hFFFF;
    wait_done("t2_done_seen", 500);
    check("t2_done_port", {30'd0, bus.done}, 2);
    bus.req[1] = 1'b0;
    check("t2_rx_cnt", rx_cnt - base, 3);
    check("t2_bus_len", bus_log.size(), 10);
    if (bus_log.size() > 1) check("t2_sel_mask", {12'd0, bus_log[1]}, {12'd0, 1'b0, 3'd5, 16'h0003});
    sson_n = 0; ssoff_n = 0;
    foreach (bus_log[i]) begin
      if (bus_log[i] == {1'b0, 3'd3, 16'h0400}) sson_n++;
      if (bus_log[i] == {1'b0, 3'd3, 16'h0000}) ssoff_n++;
    end
    check("t2_sson_once", sson_n, 1);
    check("t2_ssoff_once", ssoff_n, 1);
    repeat (3) @(negedge clk);

    // Test 3: both ports request continuously for four transactions.
    grant_log.delete();
    bus.req_len = '0;
    bus.req_ss  = {16'h0002, 16'h0001};
    txq0.push_back({8'd0, 8'h30}); txq1.push_back({8'd0, 8'h31});
    txq0.push_back({8'd0, 8'h32}); txq1.push_back({8'd0, 8'h33});
    exp_q.push_back(8'h30); exp_q.push_back(8'h31);
    exp_q.push_back(8'h32); exp_q.push_back(8'h33);
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      wait_done("t3_done_seen", 300);
      check("t3_done_order", {30'd0, bus.done}, (k % 2 == 1) ? 32'd2 : 32'd1);
    end
    bus.req = 2'b00;
    check("t3_grant_cnt", grant_log.size(), 4);
    if (grant_log.size() == 4)
      for (int k = 0; k < 4; k++)
        check("t3_grant_order", {30'd0, grant_log[k]}, (k % 2 == 1) ? 32'd2 : 32'd1);
    repeat (3) @(negedge clk);

    // Test 4: port 0 stalls 50 cycles before its second byte.
    base = rx_cnt;
    txq0.push_back({8'd0, 8'hA0}); txq0.push_back({8'd50, 8'hB1}); txq0.push_back({8'd0, 8'hC2});
    exp_q.push_back(8'hA0); exp_q.push_back(8'hB1); exp_q.push_back(8'hC2);
    bus.req_len[7:0] = 8'd2;
    bus.req[0] = 1'b1;
    wait_rx("t4_first_rx", base + 1, 300);
    w = wr1_cnt;
    repeat (3) @(negedge clk);
    n = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.tx_ready !== 2'b01) n++;
    end
    check("t4_tx_ready_held", n, 0);
    check("t4_no_tx_write", wr1_cnt, w);
    wait_done("t4_done_seen", 500);
    check("t4_done_port", {30'd0, bus.done}, 1);
    bus.req[0] = 1'b0;
    check("t4_rx_cnt", rx_cnt - base, 3);
    repeat (3) @(negedge clk);

    // Test 5: len 0xFF gives 256 bytes.
    base = rx_cnt;
    for (int i = 0; i < 256; i++) begin
      txq0.push_back({8'd0, 8'(i)});
      exp_q.push_back(8'(i ^ 8'h5C));
    end
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
    bus.req_len[7:0] = 8'hFF;
    bus.req[0] = 1'b1;
    wait_done("t5_done_seen", 8000);
    check("t5_done_port", {30'd0, bus.done}, 1);
    bus.req[0] = 1'b0;
    check("t5_rx_cnt", rx_cnt - base, 256);
    repeat (3) @(negedge clk);

    // Test 6: reset while waiting for the second byte, then a port 1 transaction.
    base = wr1_cnt;
    txq0.push_back({8'd0, 8'h5A}); txq0.push_back({8'd0, 8'h6B});
    exp_q.push_back(8'h5A);
    bus.req_len[7:0] = 8'd1;
    bus.req[0] = 1'b1;
    n = 0;
    while (!(dbg_state == 4'd6 && wr1_cnt == base + 2) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_rxwait", {31'd0, dbg_state == 4'd6}, 1);
    reset = 1'b1;
    bus.req[0] = 1'b0;
    #1;
    check("t6_rst_grant",   {30'd0, bus.grant}, 0);
    check("t6_rst_handsh",  {26'd0, bus.tx_ready, bus.rx_valid, bus.done}, 0);
    check("t6_rst_spi",     {13'd0, bus.spi_select, bus.spi_read_n, bus.spi_write_n,
                             bus.spi_mem_addr == 3'd0, bus.spi_data_from_cpu[11:0] == 12'd0,
                             bus.spi_data_from_cpu[15:12]}, {13'd0, 3'b011, 2'b11, 4'd0});
    check("t6_rst_rx_data", {24'd0, bus.rx_data}, 0);
    check("t6_rst_state",   {28'd0, dbg_state}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    base = rx_cnt;
    txq1.push_back({8'd0, 8'h77});
    exp_q.push_back(8'h77);
    bus.req_len[15:8] = 8'd0;
    bus.req_ss[31:16] = 16'h0002;
    bus.req[1] = 1'b1;
    @(negedge clk);
    check("t6_grant_p1", {30'd0, bus.grant}, 2);
    wait_done("t6_done_seen", 300);
    check("t6_done_port", {30'd0, bus.done}, 2);
    bus.req[1] = 1'b0;
    check("t6_rx_cnt", rx_cnt - base, 1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
